detect_window_ctrl: RTL and testbench

//  Front-end sequencer for the 16-channel neuron seizure detector.

---
 rtl/detect_window_ctrl.sv | 148 ++++++++++++++
 tb/tb_detect_window_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_window_ctrl.sv
// Front-end sequencer for the 16-channel seizure detector: frame assembly,
// datapath strobing, window timing and debounced seizure alarm.
module detect_window_ctrl #(
  parameter int IN_W    = 32,
  parameter int N_CH    = 16,
  parameter int WIN_LEN = 40,
  parameter int DP_LAT  = 4,
  parameter int CONSEC  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [3:0]           s_chan,
  input  logic [IN_W-1:0]      s_data,
  output logic [N_CH*IN_W-1:0] frame_data,
  output logic                 en_n,
  output logic                 dp_clr,
  input  logic                 seizure_in,
  output logic                 window_done,
  output logic                 alarm,
  output logic                 dup_err
);

  localparam int FCW = $clog2(WIN_LEN);
  localparam int LCW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam int CW  = $clog2(CONSEC + 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, COLLECT, ISSUE, WAIT, SAMPLE
  } state_e;

  state_e              state_q, state_d;
  logic [N_CH*IN_W-1:0] frame_q;
  logic [N_CH-1:0]     mask_q;
  logic [FCW-1:0]      frame_cnt_q;
  logic [LCW-1:0]      lat_cnt_q;
  logic [CW-1:0]       consec_q;
  logic                alarm_q, dup_q;
  logic                s_ready_q, en_n_q, dp_clr_q, wd_q;
  logic                s_ready_d, en_n_d, dp_clr_d, wd_d;

  logic                acc, full, last_frame, lat_done;
  logic [N_CH-1:0]     mask_set;
  logic [CW-1:0]       consec_inc;

  assign acc        = s_valid & s_ready_q & (state_q == COLLECT);
  assign mask_set   = mask_q | (N_CH'(1) << s_chan);
  assign full       = &mask_set;
  assign last_frame = frame_cnt_q == FCW'(WIN_LEN - 1);
  assign lat_done   = lat_cnt_q == LCW'(DP_LAT - 1);
  assign consec_inc = (consec_q == CW'(CONSEC)) ? consec_q
                                                : consec_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b0;
      en_n_q    <= 1'b1;
      dp_clr_q  <= 1'b0;
      wd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      en_n_q    <= en_n_d;
      dp_clr_q  <= dp_clr_d;
      wd_q      <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (run) state_d = CLEAR;
      CLEAR:   state_d = COLLECT;
      COLLECT: begin
        if (!run)             state_d = IDLE;
        else if (acc && full) state_d = ISSUE;
      end
      ISSUE:   state_d = last_frame ? WAIT : COLLECT;
      WAIT:    if (lat_done) state_d = SAMPLE;
      SAMPLE:  state_d = run ? CLEAR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they align with it
  always_comb begin
    s_ready_d = state_d == COLLECT;
    en_n_d    = state_d != ISSUE;
    dp_clr_d  = state_d == CLEAR;
    wd_d      = state_d == SAMPLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q     <= '0;
      mask_q      <= '0;
      frame_cnt_q <= '0;
      lat_cnt_q   <= '0;
      consec_q    <= '0;
      alarm_q     <= 1'b0;
      dup_q       <= 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          frame_cnt_q <= '0;
          mask_q      <= '0;
        end
        COLLECT: begin
          if (!run) begin
            mask_q <= '0;
          end else if (acc) begin
            frame_q[s_chan*IN_W +: IN_W] <= s_data;
            mask_q <= mask_set;
            if (mask_q[s_chan]) dup_q <= 1'b1;
          end
        end
        ISSUE: begin
          mask_q      <= '0;
          frame_cnt_q <= frame_cnt_q + 1'b1;
          lat_cnt_q   <= '0;
        end
        WAIT: lat_cnt_q <= lat_cnt_q + 1'b1;
        SAMPLE: begin
          if (seizure_in) begin
            consec_q <= consec_inc;
            alarm_q  <= consec_inc == CW'(CONSEC);
          end else begin
            consec_q <= '0;
            alarm_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign en_n        = en_n_q;
  assign dp_clr      = dp_clr_q;
  assign window_done = wd_q;
  assign frame_data  = frame_q;
  assign alarm       = alarm_q;
  assign dup_err     = dup_q;

endmodule

// File: tb/tb_detect_window_ctrl.sv
// Directed bench for detect_window_ctrl: frame issue, window timing,
// debounce, duplicate tags and abort with WIN_LEN=4, DP_LAT=4, CONSEC=3.
module tb_detect_window_ctrl;

  localparam int IN_W = 32;

  logic             clk, rst, run, s_valid, s_ready;
  logic [3:0]       s_chan;
  logic [IN_W-1:0]  s_data;
  logic [16*IN_W-1:0] frame_data;
  logic             en_n, dp_clr, seizure_in;
  logic             window_done, alarm, dup_err;

  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  int dp_cnt = 0;
  int wd_cnt = 0;

  detect_window_ctrl #(
    .IN_W(IN_W), .N_CH(16), .WIN_LEN(4), .DP_LAT(4), .CONSEC(3)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_chan(s_chan), .s_data(s_data),
    .frame_data(frame_data), .en_n(en_n), .dp_clr(dp_clr),
    .seizure_in(seizure_in), .window_done(window_done),
    .alarm(alarm), .dup_err(dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sample the cycle that ends at each rising edge
  always @(posedge clk) begin
    if (!en_n) en_cnt++;
    if (dp_clr) dp_cnt++;
    if (window_done) wd_cnt++;
  end

  task automatic beat(input logic [3:0] c, input logic [31:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_chan  = c;
    s_data  = d;
    while (!s_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout tag=%0d s_ready=%0b exp=1", c, s_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int order, input logic [31:0] base);
    logic [3:0] t;
    for (int i = 0; i < 16; i++) begin
      t = (order == 0) ? 4'(i) : 4'(15 - i);
      beat(t, base + 32'(t) * 3);
    end
  endtask

  task automatic wait_wd(output logic a_at_done);
    int n;
    n = 0;
    a_at_done = 1'b0;
    while (!window_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!window_done) begin
      failures++;
      $display("FAIL window_done_timeout got=0 exp=1");
    end
    a_at_done = alarm;
    @(negedge clk);
  endtask

  task automatic run_window(input logic s, output logic a_at_done);
    seizure_in = s;
    for (int f = 0; f < 4; f++) send_frame(0, 32'h1000 * f);
    wait_wd(a_at_done);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || en_n !== 1'b1 || dp_clr !== 1'b0) begin
      failures++;
      $display("FAIL rst_strobes got=%b%b%b exp=010",
               s_ready, en_n, dp_clr);
    end
    checks++;
    if (window_done !== 1'b0 || alarm !== 1'b0 || dup_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_flags got=%b%b%b exp=000",
               window_done, alarm, dup_err);
    end
    checks++;
    if (frame_data !== '0) begin
      failures++;
      $display("FAIL rst_frame got=%0h exp=0", frame_data);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({s_ready, en_n, alarm, dup_err, dp_clr} !== 5'b01000) begin
        failures++;
        $display("FAIL idle_cyc%0d got=%b exp=01000", i,
                 {s_ready, en_n, alarm, dup_err, dp_clr});
      end
    end
  endtask

  int en0;

  task automatic test_single_frame;
    en0 = en_cnt;
    run = 1'b1;
    @(negedge clk);
    checks++;
    if (dp_clr !== 1'b1 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL start_clear got=%b%b exp=10", dp_clr, s_ready);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || dp_clr !== 1'b0) begin
      failures++;
      $display("FAIL collect_ready got=%b%b exp=10", s_ready, dp_clr);
    end
    send_frame(1, 32'h0);
    checks++;
    if (en_n !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL issue_strobe got=%b%b exp=00", en_n, s_ready);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (frame_data[k*IN_W +: IN_W] !== 32'(k * 3)) begin
        failures++;
        $display("FAIL slot%0d got=%0h exp=%0h", k,
                 frame_data[k*IN_W +: IN_W], k * 3);
      end
    end
    @(negedge clk);
    checks++;
    if (en_n !== 1'b1 || s_ready !== 1'b1 || en_cnt - en0 !== 1) begin
      failures++;
      $display("FAIL post_issue got=%b%b cnt=%0d exp=11 cnt=1",
               en_n, s_ready, en_cnt - en0);
    end
  endtask

  task automatic test_window;
    seizure_in = 1'b1;
    send_frame(0, 32'h100);
    send_frame(0, 32'h200);
    send_frame(0, 32'h300);
    checks++;
    if (en_n !== 1'b0) begin
      failures++;
      $display("FAIL last_issue got=%b exp=0", en_n);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (k <= 4 && {s_ready, en_n, window_done} !== 3'b010) begin
        failures++;
        $display("FAIL wait_k%0d got=%b exp=010", k,
                 {s_ready, en_n, window_done});
      end else if (k == 5 && {window_done, dp_clr} !== 2'b10) begin
        failures++;
        $display("FAIL wd_k5 got=%b exp=10", {window_done, dp_clr});
      end else if (k == 6 && {window_done, dp_clr, alarm} !== 3'b010) begin
        failures++;
        $display("FAIL clr_k6 got=%b exp=010",
                 {window_done, dp_clr, alarm});
      end else if (k == 7 && (s_ready !== 1'b1 || en_cnt - en0 !== 4)) begin
        failures++;
        $display("FAIL k7 got=%b cnt=%0d exp=1 cnt=4",
                 s_ready, en_cnt - en0);
      end
    end
  endtask

  task automatic test_debounce;
    logic ad;
    logic exp_a [6];
    logic seq [6];
    seq   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int w = 0; w < 6; w++) begin
      run_window(seq[w], ad);
      checks++;
      if (alarm !== exp_a[w]) begin
        failures++;
        $display("FAIL alarm_w%0d got=%b exp=%b", w + 2, alarm, exp_a[w]);
      end
      if (w == 4) begin
        checks++;
        if (ad !== 1'b0) begin
          failures++;
          $display("FAIL alarm_early got=%b exp=0", ad);
        end
      end
    end
  endtask

  task automatic test_dup;
    checks++;
    if (dup_err !== 1'b0) begin
      failures++;
      $display("FAIL dup_pre got=%b exp=0", dup_err);
    end
    en0 = en_cnt;
    beat(4'd0, 32'h0);
    beat(4'd1, 32'h11);
    beat(4'd1, 32'h55);
    checks++;
    if (dup_err !== 1'b1) begin
      failures++;
      $display("FAIL dup_set got=%b exp=1", dup_err);
    end
    for (int t = 2; t < 16; t++) beat(4'(t), 32'(t * 3));
    checks++;
    if (en_n !== 1'b0 || en_cnt !== en0) begin
      failures++;
      $display("FAIL dup_issue got=%b cnt=%0d exp=0 cnt=0",
               en_n, en_cnt - en0);
    end
    checks++;
    if (frame_data[1*IN_W +: IN_W] !== 32'h55 ||
        frame_data[2*IN_W +: IN_W] !== 32'h6) begin
      failures++;
      $display("FAIL dup_slots got=%0h,%0h exp=55,6",
               frame_data[1*IN_W +: IN_W], frame_data[2*IN_W +: IN_W]);
    end
    @(negedge clk);
    checks++;
    if (dup_err !== 1'b1 || en_cnt - en0 !== 1) begin
      failures++;
      $display("FAIL dup_sticky got=%b cnt=%0d exp=1 cnt=1",
               dup_err, en_cnt - en0);
    end
  endtask

  task automatic test_abort;
    int dp0, wd0;
    logic ad;
    for (int t = 0; t < 8; t++) beat(4'(t), 32'h200 + 32'(t));
    run = 1'b0;
    en0 = en_cnt;
    dp0 = dp_cnt;
    repeat (6) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || en_cnt !== en0 || dp_cnt !== dp0) begin
      failures++;
      $display("FAIL abort_idle got=%b en=%0d clr=%0d exp=0 en=0 clr=0",
               s_ready, en_cnt - en0, dp_cnt - dp0);
    end
    run = 1'b1;
    @(negedge clk);
    checks++;
    if (dp_clr !== 1'b1) begin
      failures++;
      $display("FAIL abort_clr got=%b exp=1", dp_clr);
    end
    wd0 = wd_cnt;
    for (int t = 8; t < 16; t++) beat(4'(t), 32'h300 + 32'(t));
    checks++;
    if (en_n !== 1'b1 || en_cnt !== en0) begin
      failures++;
      $display("FAIL abort_mask got=%b cnt=%0d exp=1 cnt=0",
               en_n, en_cnt - en0);
    end
    for (int t = 0; t < 8; t++) beat(4'(t), 32'h300 + 32'(t));
    checks++;
    if (en_n !== 1'b0) begin
      failures++;
      $display("FAIL abort_issue got=%b exp=0", en_n);
    end
    send_frame(0, 32'h400);
    send_frame(0, 32'h500);
    repeat (2) @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || wd_cnt !== wd0) begin
      failures++;
      $display("FAIL abort_cnt got=%b wd=%0d exp=1 wd=0",
               s_ready, wd_cnt - wd0);
    end
    send_frame(0, 32'h600);
    wait_wd(ad);
    checks++;
    if (dup_err !== 1'b1 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL final_flags got=%b%b exp=10", dup_err, alarm);
    end
  endtask

  initial begin
    run = 1'b0;
    s_valid = 1'b0;
    s_chan = '0;
    s_data = '0;
    seizure_in = 1'b0;
    test_reset;
    test_single_frame;
    test_window;
    test_debounce;
    test_dup;
    test_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
